// File: rtl/dnn_weight_scheduler.sv
// Streams weight rows into a chain of dense systolic layers: counts rows per layer,
// masks unused lanes and tags each registered row with its one-hot target layer.
module dnn_weight_scheduler #(
  parameter int unsigned NumLayers    = 4,
  parameter int unsigned MaxNumNerves = 6,
  parameter int unsigned M_W_BitSize  = 16,
  parameter int unsigned ImageSize    = 16,
  parameter int          LNN [NumLayers-1:0] = '{2, 3, 5, 6},
  localparam int         RowW   = $clog2(max_rows()) + 1,
  localparam int         LayerW = (NumLayers > 1) ? $clog2(NumLayers) : 1
) (
  input  logic                                      clk,
  input  logic                                      res,
  input  logic                                      in_start,
  input  logic                                      in_abort,
  input  logic                                      in_w_valid,
  input  logic [MaxNumNerves-1:0][M_W_BitSize-1:0]  in_weights,
  output logic                                      out_w_ready,
  output logic [MaxNumNerves-1:0][M_W_BitSize-1:0]  out_weights,
  output logic                                      out_w_valid,
  output logic [NumLayers-1:0]                      out_layer_load,
  output logic [RowW-1:0]                           out_row,
  output logic                                      out_busy,
  output logic                                      out_done
);

  // Largest row count of any layer; sizes the row counter and out_row.
  function automatic int max_rows();
    int m;
    m = int'(ImageSize);
    for (int unsigned k = 1; k < NumLayers; k++) begin
      if (LNN[k-1] > m) m = LNN[k-1];
    end
    return m;
  endfunction

  // Layer 0 takes image rows; every later layer takes one row per nerve of its predecessor.
  function automatic int rows_of(input logic [LayerW-1:0] k);
    if (k == '0) return int'(ImageSize);
    return LNN[k - LayerW'(1)];
  endfunction

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e              state_q, state_d;
  logic [LayerW-1:0]   layer_q, layer_d;
  logic [RowW-1:0]     row_q, row_d;
  logic                beat;
  logic                row_last;
  logic                layer_last;
  logic [MaxNumNerves-1:0][M_W_BitSize-1:0] masked;
  logic [NumLayers-1:0] layer_oh;

  assign beat       = (state_q == StLoad) && !in_abort && in_w_valid;
  assign row_last   = (int'(row_q) == rows_of(layer_q) - 1);
  assign layer_last = (layer_q == LayerW'(NumLayers - 1));

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= StIdle;
      layer_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        if (in_start) begin
          state_d = StLoad;
          layer_d = '0;
          row_d   = '0;
        end
      end
      StLoad: begin
        // Abort wins over a beat offered in the same cycle.
        if (in_abort) begin
          state_d = StIdle;
          layer_d = '0;
          row_d   = '0;
        end else if (in_w_valid) begin
          if (row_last) begin
            row_d = '0;
            if (layer_last) begin
              state_d = StDone;
              layer_d = '0;
            end else begin
              layer_d = layer_q + LayerW'(1);
            end
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_w_ready = (state_q == StLoad) && !in_abort;
    out_busy    = (state_q == StLoad) || (state_q == StDone);
  end

  // Only the top LNN[k] lanes carry weights for layer k.
  always_comb begin
    masked = '0;
    for (int i = 0; i < int'(MaxNumNerves); i++) begin
      if (i >= int'(MaxNumNerves) - LNN[layer_q]) masked[i] = in_weights[i];
    end
  end

  always_comb begin
    layer_oh          = '0;
    layer_oh[layer_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      out_weights    <= '0;
      out_w_valid    <= 1'b0;
      out_layer_load <= '0;
      out_row        <= '0;
      out_done       <= 1'b0;
    end else begin
      out_w_valid    <= beat;
      out_layer_load <= beat ? layer_oh : '0;
      if (beat) begin
        out_weights <= masked;
        out_row     <= row_q;
      end
      // Delayed one cycle past DONE so it never overlaps the last row's valid.
      out_done <= (state_q == StDone);
    end
  end

endmodule

// File: tb/tb_dnn_weight_scheduler.sv
// Directed and randomized checks of dnn_weight_scheduler against a beat-indexed reference model.
module tb_dnn_weight_scheduler;

  typedef logic [5:0][15:0] wvec_t;
  localparam int Total = 30;

  logic       clk = 1'b0;
  logic       res, in_start, in_abort, in_w_valid;
  wvec_t      in_weights;
  logic       out_w_ready, out_w_valid, out_busy, out_done;
  wvec_t      out_weights;
  logic [3:0] out_layer_load;
  logic [4:0] out_row;

  dnn_weight_scheduler dut (
    .clk           (clk),
    .res           (res),
    .in_start      (in_start),
    .in_abort      (in_abort),
    .in_w_valid    (in_w_valid),
    .in_weights    (in_weights),
    .out_w_ready   (out_w_ready),
    .out_weights   (out_weights),
    .out_w_valid   (out_w_valid),
    .out_layer_load(out_layer_load),
    .out_row       (out_row),
    .out_busy      (out_busy),
    .out_done      (out_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Nerve counts LNN[0..3] and rows per layer derived from them.
  int lnn_tb [4] = '{6, 5, 3, 2};
  int rows_tb[4];
  int layer_of[Total];
  int row_of[Total];

  // Reference model state
  bit    m_load, m_in_done;
  int    m_n;
  bit    e_valid, e_done;
  logic [3:0] e_ll;
  logic [4:0] e_row;
  wvec_t e_w;

  int cyc, last_beat_cyc, done_cyc;
  int ready_cnt, vcnt, done_cnt;
  int lcnt[4];
  bit seen_l3;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wvec_t mask_row(input wvec_t w, input int k);
    wvec_t r;
    r = '0;
    for (int i = 0; i < 6; i++) if (i >= 6 - lnn_tb[k]) r[i] = w[i];
    return r;
  endfunction

  function automatic wvec_t rw();
    wvec_t w;
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    return w;
  endfunction

  task automatic clear_counts();
    ready_cnt = 0; vcnt = 0; done_cnt = 0; done_cyc = -1; last_beat_cyc = -100;
    for (int k = 0; k < 4; k++) lcnt[k] = 0;
  endtask

  task automatic step();
    bit beat, was_load, was_done;
    #1;
    check("w_ready", out_w_ready, m_load && !in_abort);
    check("busy", out_busy, m_load || m_in_done);
    if (out_w_ready) ready_cnt++;
    @(posedge clk);
    was_load = m_load;
    was_done = m_in_done;
    if (res) begin
      m_load = 0; m_in_done = 0; m_n = 0;
      e_valid = 0; e_ll = '0; e_row = '0; e_w = '0; e_done = 0;
    end else begin
      e_done  = was_done;
      beat    = was_load && !in_abort && in_w_valid;
      e_valid = beat;
      e_ll    = '0;
      if (beat) begin
        e_w   = mask_row(in_weights, layer_of[m_n]);
        e_ll  = 4'(1 << layer_of[m_n]);
        e_row = 5'(row_of[m_n]);
        m_n++;
        if (m_n == Total) begin
          m_n = 0; m_load = 0; m_in_done = 1; last_beat_cyc = cyc;
        end
      end
      if (was_load && in_abort) begin m_load = 0; m_n = 0; end
      if (was_done) m_in_done = 0;
      else if (!was_load && in_start) begin m_load = 1; m_n = 0; end
    end
    cyc++;
    #1;
    check("w_valid", out_w_valid, e_valid);
    check("layer_load", out_layer_load, e_ll);
    check("row", out_row, e_row);
    check("weights", out_weights, e_w);
    check("done", out_done, e_done);
    if (out_w_valid) begin
      vcnt++;
      for (int k = 0; k < 4; k++) if (out_layer_load[k]) lcnt[k]++;
    end
    if (out_done) begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic drive(input logic r, input logic s, input logic a, input logic v, input wvec_t w);
    res = r; in_start = s; in_abort = a; in_w_valid = v; in_weights = w;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    wvec_t ones;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      rows_tb[k] = (k == 0) ? 16 : lnn_tb[k-1];
      for (int r = 0; r < rows_tb[k]; r++) begin
        layer_of[idx] = k; row_of[idx] = r; idx++;
      end
    end
    for (int i = 0; i < 6; i++) ones[i] = 16'hFFFF;
    cyc = 0; m_load = 0; m_in_done = 0; m_n = 0;
    clear_counts();

    // Reset, including reset overriding start/abort
    res = 1; in_start = 0; in_abort = 0; in_w_valid = 0; in_weights = '0;
    @(posedge clk); #1;
    drive(1, 0, 0, 0, rw());
    drive(1, 1, 1, 1, rw());
    drive(0, 0, 1, 1, rw());
    drive(0, 0, 0, 0, rw());

    // Full load, valid always high, stray start mid-load
    clear_counts();
    drive(0, 1, 0, 0, rw());
    for (int c = 0; c < 40 && done_cnt == 0; c++) drive(0, (c == 10), 0, 1, rw());
    check("full_beats", vcnt, 30);
    check("l0_cycles", lcnt[0], 16);
    check("l1_cycles", lcnt[1], 6);
    check("l2_cycles", lcnt[2], 5);
    check("l3_cycles", lcnt[3], 3);
    check("done_count", done_cnt, 1);
    check("done_latency", done_cyc - last_beat_cyc, 2);

    // Lane masking with all-ones weights; start in DONE cycle is not queued
    clear_counts();
    seen_l3 = 0;
    drive(0, 1, 0, 0, ones);
    for (int c = 0; c < 40 && done_cnt == 0; c++) begin
      drive(0, m_in_done, 0, 1, ones);
      if (out_w_valid && out_layer_load == 4'b1000 && !seen_l3) begin
        seen_l3 = 1;
        check("mask_l3", out_weights, {16'hFFFF, 16'hFFFF, 64'h0});
      end
    end
    check("mask_seen_l3", seen_l3, 1'b1);
    drive(0, 0, 0, 0, rw());
    check("no_queued_start", out_busy, 1'b0);

    // Backpressure: valid toggles every cycle
    clear_counts();
    drive(0, 1, 0, 0, rw());
    for (int c = 0; c < 80 && done_cnt == 0; c++) drive(0, 0, 0, (c % 2 == 0), rw());
    check("gap_ready_cycles", ready_cnt, 59);
    check("gap_beats", vcnt, 30);
    check("gap_done", done_cnt, 1);

    // Abort on beat 20 (layer 1, row 3), then restart
    clear_counts();
    drive(0, 1, 0, 0, rw());
    for (int c = 0; c < 40 && m_n != 19; c++) drive(0, 0, 0, 1, rw());
    check("abort_at_19", m_n, 19);
    drive(0, 0, 1, 1, rw());
    check("abort_idle", out_busy, 1'b0);
    repeat (3) drive(0, 0, 0, 1, rw());
    check("abort_no_done", done_cnt, 0);
    drive(0, 1, 0, 0, rw());
    drive(0, 0, 0, 1, rw());
    check("restart_row", out_row, 5'd0);
    check("restart_layer", out_layer_load, 4'b0001);
    drive(0, 0, 1, 0, rw());

    // Abort together with the 30th beat
    clear_counts();
    drive(0, 1, 0, 0, rw());
    for (int c = 0; c < 40 && m_n != 29; c++) drive(0, 0, 0, 1, rw());
    drive(0, 0, 1, 1, rw());
    check("abort_last_valid", out_w_valid, 1'b0);
    repeat (3) drive(0, 0, 0, 0, rw());
    check("abort_last_no_done", done_cnt, 0);

    // Reset at beat 10
    clear_counts();
    drive(0, 1, 0, 0, rw());
    for (int c = 0; c < 40 && m_n != 9; c++) drive(0, 0, 0, 1, rw());
    drive(1, 0, 0, 1, rw());
    check("rst_weights", out_weights, '0);
    check("rst_row", out_row, 5'd0);
    check("rst_valid", out_w_valid, 1'b0);
    drive(0, 0, 0, 1, rw());
    check("rst_idle", out_busy, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rw());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
